// File: rtl/vga_image_writer_if.sv
// ============================================================================
// Module      : vga_image_writer_if
// Description : Pixel-stream handshake and memory-write bus for the image loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_image_writer_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [16:0]       mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [1:0]        image_index;
  logic [7:0]        col;
  logic [7:0]        row;
  logic              busy;
  logic              done;

  modport master (
    output start, pixel_data, pixel_valid,
    input  pixel_ready, mem_address, mem_data, mem_wren,
    input  image_index, col, row, busy, done
  );

  modport slave (
    input  start, pixel_data, pixel_valid,
    output pixel_ready, mem_address, mem_data, mem_wren,
    output image_index, col, row, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/vga_image_writer.sv
// ============================================================================
// Module      : vga_image_writer
// Description : Streams NUM_IMG raster images into VGA memory, then blanks one word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_image_writer #(
  parameter int          IMG_W      = 150,
  parameter int          IMG_H      = 150,
  parameter int          NUM_IMG    = 3,
  parameter int          DATA_W     = 8,
  parameter logic [16:0] BLANK_ADDR = 17'h107AC
) (
  input  logic              clock,
  input  logic              reset,
  vga_image_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_BLANK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_last_col = 8'(IMG_W - 1);
  localparam logic [7:0] c_last_row = 8'(IMG_H - 1);
  localparam logic [1:0] c_last_img = 2'(NUM_IMG - 1);

  state_t            r_state;
  logic [7:0]        r_col;
  logic [7:0]        r_row;
  logic [1:0]        r_img;
  logic [16:0]       r_lin;
  logic [16:0]       r_mem_address;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wren;
  logic              r_pixel_ready;
  logic              r_busy;
  logic              r_done;

  logic w_accept;
  logic w_last_col;
  logic w_last_row;
  logic w_last_pixel;

  assign w_accept     = bus.pixel_valid & r_pixel_ready;
  assign w_last_col   = (r_col == c_last_col);
  assign w_last_row   = (r_row == c_last_row);
  assign w_last_pixel = w_last_col & w_last_row & (r_img == c_last_img);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_img         <= '0;
      r_lin         <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_wren    <= 1'b0;
      r_pixel_ready <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_mem_wren <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state       <= S_WRITE;
            r_col         <= '0;
            r_row         <= '0;
            r_img         <= '0;
            r_lin         <= '0;
            r_pixel_ready <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            // The linear counter tracks img*W*H + row*W + col without a multiplier.
            r_mem_wren    <= 1'b1;
            r_mem_address <= r_lin;
            r_mem_data    <= bus.pixel_data;
            if (w_last_pixel) begin
              r_state       <= S_BLANK;
              r_pixel_ready <= 1'b0;
            end else begin
              r_lin <= r_lin + 17'd1;
              if (w_last_col) begin
                r_col <= '0;
                if (w_last_row) begin
                  r_row <= '0;
                  r_img <= r_img + 2'd1;
                end else begin
                  r_row <= r_row + 8'd1;
                end
              end else begin
                r_col <= r_col + 8'd1;
              end
            end
          end
        end
        S_BLANK: begin
          r_mem_wren    <= 1'b1;
          r_mem_address <= BLANK_ADDR;
          r_mem_data    <= '0;
          r_busy        <= 1'b0;
          r_state       <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_col   <= '0;
          r_row   <= '0;
          r_img   <= '0;
          r_lin   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pixel_ready = r_pixel_ready;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data    = r_mem_data;
  assign bus.mem_wren    = r_mem_wren;
  assign bus.image_index = r_img;
  assign bus.col         = r_col;
  assign bus.row         = r_row;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

`default_nettype wire
